wallace_signed_multiplier4: RTL and testbench

Registered 4×4 two's-complement multiplier built from a Baugh-Wooley partial-product array reduced by a Wallace tree of half and full adders, followed by a final carry-propagate adder. It is the smallest member of the fast-multiplier family and serves as the signed arithmetic leaf used by wider datapaths and by the multiplier regression benches. The result is exact over the full signed input range and is captured in an output register on the clock edge.

---
 rtl/wallace_signed_multiplier4_if.sv | 9 +
 rtl/wallace_signed_multiplier4.sv | 96 +++++++++
 tb/tb_wallace_signed_multiplier4.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wallace_signed_multiplier4_if.sv
// Operand/result bundle for wallace_signed_multiplier4. The master drives A/B and the slave returns product.
interface wallace_signed_multiplier4_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] product;

  modport master (output A, output B, input product);
  modport slave  (input A, input B, output product);
endinterface

// File: rtl/wallace_signed_multiplier4.sv
// Registered 4x4 signed multiplier: Baugh-Wooley partial products, Wallace reduction and a ripple final adder.
// Define WALLACE_MUL_PIPE_EN to add an input register stage, which makes the latency 2 cycles.
module wallace_signed_multiplier4 (
  input  logic                          clk,
  input  logic                          rst,
  wallace_signed_multiplier4_if.slave   bus
);

  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [3:0] op_a, op_b;

`ifdef WALLACE_MUL_PIPE_EN
  logic [3:0] a_d, b_d, a_q, b_q;

  always_comb begin
    a_d = bus.A;
    b_d = bus.B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  always_comb begin
    op_a = a_q;
    op_b = b_q;
  end
`else
  always_comb begin
    op_a = bus.A;
    op_b = bus.B;
  end
`endif

  logic [3:0] pp [4];
  logic       s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4, c1_4, s1_5, c1_5;
  logic       s2_2, c2_2, s2_3, c2_3, s2_4, c2_4, s2_5, c2_5, s2_6, c2_6;
  logic [7:0] row0, row1, sum;
  logic       carry;
  logic [7:0] product_d, product_q;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        pp[i[1:0]][j[1:0]] = op_a[j[1:0]] & op_b[i[1:0]];
        if ((i == 3) != (j == 3)) pp[i[1:0]][j[1:0]] = ~pp[i[1:0]][j[1:0]];
      end
    end

    // Stage 1 heights by column 0..7: 1,2,3,4,4(incl. const 1),2,1,1(const 1)
    {c1_1, s1_1} = ha(pp[0][1], pp[1][0]);
    {c1_2, s1_2} = fa(pp[0][2], pp[1][1], pp[2][0]);
    {c1_3, s1_3} = fa(pp[0][3], pp[1][2], pp[2][1]);
    {c1_4, s1_4} = fa(pp[1][3], pp[2][2], pp[3][1]);
    {c1_5, s1_5} = ha(pp[2][3], pp[3][2]);

    // Stage 2: pp[3][0] and the bit-4 constant were passed through stage 1
    {c2_2, s2_2} = ha(s1_2, c1_1);
    {c2_3, s2_3} = fa(s1_3, pp[3][0], c1_2);
    {c2_4, s2_4} = fa(s1_4, 1'b1, c1_3);
    {c2_5, s2_5} = ha(s1_5, c1_4);
    {c2_6, s2_6} = ha(pp[3][3], c1_5);

    row0 = {1'b1, s2_6, s2_5, s2_4, s2_3, s2_2, s1_1, pp[0][0]};
    row1 = {c2_6, c2_5, c2_4, c2_3, c2_2, 3'b000};

    sum   = '0;
    carry = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      {carry, sum[k[2:0]]} = fa(row0[k[2:0]], row1[k[2:0]], carry);
    end

    product_d = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) product_q <= '0;
    else     product_q <= product_d;
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_wallace_signed_multiplier4.sv
// Self-checking bench for wallace_signed_multiplier4 against a signed arithmetic reference with latency queue.
module tb_wallace_signed_multiplier4;

`ifdef WALLACE_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wallace_signed_multiplier4_if bus ();

  wallace_signed_multiplier4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] val;
    bit         has_c;
    logic [7:0] cval;
    string      tag;
  } ent_t;

  ent_t pipe[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int x;
    int y;
    x = $signed(a);
    y = $signed(b);
    return 8'(x * y);
  endfunction

  task automatic flush_model(input string tag);
    ent_t z;
    z.val = 8'h00; z.has_c = 1'b0; z.cval = 8'h00; z.tag = tag;
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back(z);
  endtask

  // One clock: drive at negedge, check #1 after the rising edge.
  // has_c/cval attach a spec-given constant that must emerge with this pair.
  task automatic tick(input logic [3:0] a, input logic [3:0] b, input logic r,
                      input bit has_c, input logic [7:0] cval, input string tag);
    ent_t e;
    ent_t cur;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    rst   = r;
    @(posedge clk);
    #1;
    if (r) begin
      flush_model(tag);
      pipe[0].has_c = has_c;
      pipe[0].cval  = cval;
    end else begin
      e.val = ref_mul(a, b); e.has_c = has_c; e.cval = cval; e.tag = tag;
      pipe.push_back(e);
      void'(pipe.pop_front());
    end
    cur = pipe[0];
    total++;
    assert (bus.product === cur.val) else begin
      bad++;
      $error("FAIL %s model: product=%0d expected=%0d", cur.tag, $signed(bus.product), $signed(cur.val));
    end
    if (cur.has_c) begin
      total++;
      assert (bus.product === cur.cval) else begin
        bad++;
        $error("FAIL %s const: product=%0d expected=%0d", cur.tag, $signed(bus.product), $signed(cur.cval));
      end
    end
  endtask

  initial begin
    bus.A = 4'b0111;
    bus.B = 4'b0111;
    flush_model("init");

    // Reset hold: product must be zero at every reset edge.
    for (int i = 0; i < 3; i++) tick(4'b0111, 4'b0111, 1'b1, 1'b1, 8'h00, "reset_hold");
    tick(4'b0111, 4'b0111, 1'b0, 1'b1, 8'b00110001, "first_after_reset");

    // Directed signs, back to back.
    tick(4'b0010, 4'b0011, 1'b0, 1'b1, 8'b00000110, "pos_pos");
    tick(4'b1010, 4'b0011, 1'b0, 1'b1, 8'b11101110, "neg_pos");
    tick(4'b1101, 4'b1010, 1'b0, 1'b1, 8'b00010010, "neg_neg_latency");

    // Extremes.
    tick(4'b1000, 4'b1000, 1'b0, 1'b1, 8'b01000000, "min_x_min");
    tick(4'b1000, 4'b0111, 1'b0, 1'b1, 8'b11001000, "min_x_max");
    tick(4'b0000, 4'b1000, 1'b0, 1'b1, 8'b00000000, "zero_x_min");

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        tick(4'(a), 4'(b), 1'b0, 1'b0, 8'h00, "exhaustive");

    // Mid-stream reset with random nonzero operands.
    for (int i = 0; i < 8; i++)
      tick(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'b0, 1'b0, 8'h00, "pre_reset");
    tick(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'b1, 1'b1, 8'h00, "mid_reset");
    for (int i = 0; i < 20; i++)
      tick(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'b0, 1'b0, 8'h00, "post_reset");

    // Random stream with occasional resets.
    for (int i = 0; i < 200; i++)
      tick(4'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0), 1'b0, 8'h00, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
